// File: rtl/rv32_mem_pkg.sv
// Shared definitions for the load/store path: access-size encodings,
// LSU sequencer states, the registered request record and DataMem depth.
package rv32_mem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_R = 2'b11;   // reserved encoding

    localparam int DMEM_BYTES = 1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    // Request as captured on accept (address already size-aligned when
    // the address checks are compiled out).
    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        we;
        logic        uns;
        logic [31:0] wdata;
    } lsu_req_t;

endpackage

// File: rtl/lsu_ctrl_if.sv
// Bundle of the core-side request/response handshake and the DataMem port.
// The LSU takes the slave view; the core/memory environment takes master.
interface lsu_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        output mem_addr, mem_wdata, mem_we, mem_re,
        input  mem_rdata
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        input  mem_addr, mem_wdata, mem_we, mem_re,
        output mem_rdata
    );

endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering between a DataMem word and the core's right-justified
// data: load extract with sign/zero extension, and sub-word store merge.
// Purely combinational.
module lsu_lane_align
    import rv32_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  lb;
    logic [15:0] lh;

    // Pick the addressed lane(s) out of the word and extend to 32 bits.
    always_comb begin
        lb = rdata[{addr_lo, 3'b000} +: 8];
        lh = rdata[{addr_lo[1], 4'b0000} +: 16];
        case (size)
            SZ_B:    load_data = {{24{lb[7] & ~uns}}, lb};
            SZ_H:    load_data = {{16{lh[15] & ~uns}}, lh};
            default: load_data = rdata;
        endcase
    end

    // Overlay the store data onto the word read back from memory.
    always_comb begin
        store_word = rdata;
        case (size)
            SZ_B:    store_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            SZ_H:    store_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            default: store_word = wdata;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer between execute and the word-only DataMem.
// Every access becomes aligned word reads/writes; SB/SH are done as a
// read-modify-write. DataMem never sees read and write together.
// Build option: LSU_ADDR_CHECK_EN enables rejection of misaligned,
// reserved-size and out-of-range requests (rsp_err); otherwise addresses
// are forced to size alignment and size 11 is treated as a word.
module lsu_ctrl
    import rv32_mem_pkg::*;
#(
    parameter int MEM_BYTES = DMEM_BYTES
) (
    input  logic       clk,
    input  logic       rst_n,
    lsu_ctrl_if.slave  bus
);

    lsu_state_e  state, state_nxt;
    lsu_req_t    req_q;
    logic        err_q;
    logic [31:0] rd_q;

    logic        accept;
    logic        chk_err;
    logic [31:0] addr_n;
    logic [1:0]  size_n;
    logic [31:0] load_data;
    logic [31:0] store_word;

    assign accept = (state == IDLE) && bus.req_valid;

`ifdef LSU_ADDR_CHECK_EN
    localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES - 4);

    // Classify the incoming request; rejected ones never touch DataMem.
    always_comb begin
        addr_n  = bus.req_addr;
        size_n  = bus.req_size;
        chk_err = 1'b0;
        case (bus.req_size)
            SZ_H:    chk_err = bus.req_addr[0];
            SZ_W:    chk_err = |bus.req_addr[1:0];
            SZ_R:    chk_err = 1'b1;
            default: chk_err = 1'b0;
        endcase
        if (bus.req_addr > LAST_ADDR)
            chk_err = 1'b1;
    end
`else
    logic unused_cfg;
    assign unused_cfg = |MEM_BYTES;

    // No rejection: fold size 11 into word and drop the low address bits
    // the access size cannot use; upper bits pass through untouched.
    always_comb begin
        addr_n  = bus.req_addr;
        size_n  = (bus.req_size == SZ_R) ? SZ_W : bus.req_size;
        chk_err = 1'b0;
        if (size_n == SZ_H)
            addr_n[0] = 1'b0;
        if (size_n == SZ_W)
            addr_n[1:0] = 2'b00;
    end
`endif

    lsu_lane_align u_align (
        .rdata      (rd_q),
        .wdata      (req_q.wdata),
        .addr_lo    (req_q.addr[1:0]),
        .size       (req_q.size),
        .uns        (req_q.uns),
        .load_data  (load_data),
        .store_word (store_word)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Request capture on accept and read-data capture in RD.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_q <= '0;
            err_q <= 1'b0;
            rd_q  <= '0;
        end else begin
            if (accept) begin
                req_q <= '{addr: addr_n, size: size_n, we: bus.req_we,
                           uns: bus.req_unsigned, wdata: bus.req_wdata};
                err_q <= chk_err;
            end
            if (state == RD)
                rd_q <= bus.mem_rdata;
        end
    end

    // Next state and outputs, decoded from registered state only.
    // A rejected request spends its RD cycle with the memory port quiet so
    // that its response lands on the same schedule as a plain load.
    always_comb begin
        state_nxt     = state;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_rdata = '0;
        bus.rsp_err   = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_we    = 1'b0;
        bus.mem_re    = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid)
                    state_nxt = (bus.req_we && size_n == SZ_W && !chk_err) ? WR : RD;
            end
            RD: begin
                if (!err_q) begin
                    bus.mem_re   = 1'b1;
                    bus.mem_addr = {req_q.addr[31:2], 2'b00};
                end
                state_nxt = (req_q.we && !err_q) ? WR : RESP;
            end
            WR: begin
                bus.mem_we    = 1'b1;
                bus.mem_addr  = {req_q.addr[31:2], 2'b00};
                bus.mem_wdata = store_word;
                state_nxt     = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_err   = err_q;
                if (!req_q.we && !err_q)
                    bus.rsp_rdata = load_data;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: a word DataMem model on the memory port,
// and a byte-array golden memory that predicts load data, store results,
// error flags, latency and memory-port activity for each request.
module tb_lsu_ctrl;

    localparam int MEM_BYTES = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_ctrl_if bus();

    lsu_ctrl #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] dmem [0:255];
    logic [7:0]  gold [0:MEM_BYTES-1];

    assign bus.mem_rdata = dmem[bus.mem_addr[9:2]];

    // DataMem: combinational read, write committed at the clock edge.
    always @(posedge clk)
        if (bus.mem_we) dmem[bus.mem_addr[9:2]] <= bus.mem_wdata;

    int n_tot = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Memory-port invariants, every cycle.
    always @(negedge clk) begin
        chk("re_we_excl", {31'b0, bus.mem_re & bus.mem_we}, 32'd0);
        chk("addr_lo", {30'b0, bus.mem_addr[1:0]}, 32'd0);
    end

    function automatic logic [31:0] gold_word(input int a);
        int b = a - (a % 4);
        return {gold[b+3], gold[b+2], gold[b+1], gold[b]};
    endfunction

    task automatic drive(input bit we, input logic [1:0] sz, input bit uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output bit er, output int lat,
                         output int nwe, output int nre, output logic [31:0] wword);
        @(negedge clk);
        chk("ready", {31'b0, bus.req_ready}, 32'd1);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz;
        bus.req_unsigned = uns; bus.req_addr = a; bus.req_wdata = wd;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 0; nwe = 0; nre = 0; rd = '0; er = 1'b0; wword = '0;
        while (1) begin
            @(negedge clk);
            lat++;
            if (bus.mem_we) begin nwe++; wword = bus.mem_wdata; end
            if (bus.mem_re) nre++;
            if (bus.rsp_valid) begin rd = bus.rsp_rdata; er = bus.rsp_err; break; end
            if (lat >= 8) begin chk("rsp_timeout", {31'b0, bus.rsp_valid}, 32'd1); break; end
        end
    endtask

    // Predict from access rules, run the request, compare everything.
    task automatic txn(input bit we, input logic [1:0] sz, input bit uns,
                       input logic [31:0] a, input logic [31:0] wd);
        int nb, ea, e_lat, e_nwe, e_nre, lat, nwe, nre;
        bit e_err, er;
        logic [31:0] e_rd, e_word, rd, wword;
        nb = (sz == 2'd3) ? 4 : (1 << sz);
        e_err = 1'b0;
        ea = int'(a);
`ifdef LSU_ADDR_CHECK_EN
        if (sz == 2'd3 || (ea % nb) != 0 || a > 32'(MEM_BYTES - 4)) e_err = 1'b1;
`else
        ea = ea - (ea % nb);
`endif
        e_rd = '0; e_word = '0;
        if (!e_err && !we) begin
            for (int k = 0; k < nb; k++) e_rd |= 32'(gold[ea+k]) << (8*k);
            if (nb < 4 && !uns && e_rd[8*nb-1]) e_rd |= ~((32'd1 << (8*nb)) - 1);
        end
        if (!e_err && we) begin
            for (int k = 0; k < nb; k++) gold[ea+k] = wd[8*k +: 8];
            e_word = gold_word(ea);
        end
        e_lat = (!e_err && we && nb < 4) ? 3 : 2;
        e_nwe = (!e_err && we) ? 1 : 0;
        e_nre = (!e_err && (!we || nb < 4)) ? 1 : 0;

        drive(we, sz, uns, a, wd, rd, er, lat, nwe, nre, wword);
        chk("rdata", rd, e_rd);
        chk("err", {31'b0, er}, {31'b0, e_err});
        chk("latency", 32'(lat), 32'(e_lat));
        chk("n_we", 32'(nwe), 32'(e_nwe));
        chk("n_re", 32'(nre), 32'(e_nre));
        if (!e_err && we) begin
            chk("merged_word", wword, e_word);
            chk("mem_word", dmem[ea/4], e_word);
        end
    endtask

    initial begin
        logic [31:0] ra;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
        bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'b0, bus.req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_err", {31'b0, bus.rsp_err}, 32'd0);
        chk("rst_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_ctl", {30'b0, bus.mem_re, bus.mem_we}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < MEM_BYTES; i++) gold[i] = dmem[i/4][8*(i%4) +: 8];

        // Directed traffic.
        txn(1'b1, 2'd2, 1'b0, 32'h100, 32'h11223344);   // SW
        txn(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);          // LW
        txn(1'b1, 2'd0, 1'b0, 32'h101, 32'h000000AB);   // SB -> 0x1122AB44
        txn(1'b0, 2'd0, 1'b0, 32'h101, 32'h0);          // LB  -> FFFFFFAB
        txn(1'b0, 2'd0, 1'b1, 32'h101, 32'h0);          // LBU -> 000000AB
        txn(1'b1, 2'd1, 1'b0, 32'h102, 32'h00008001);   // SH
        txn(1'b0, 2'd1, 1'b0, 32'h102, 32'h0);          // LH  -> FFFF8001
        txn(1'b0, 2'd1, 1'b1, 32'h102, 32'h0);          // LHU
        txn(1'b0, 2'd3, 1'b0, 32'h100, 32'h0);          // reserved size
`ifdef LSU_ADDR_CHECK_EN
        txn(1'b0, 2'd2, 1'b0, 32'h102, 32'h0);
        txn(1'b1, 2'd1, 1'b0, 32'h103, 32'h1234);
        txn(1'b0, 2'd2, 1'b0, 32'h400, 32'h0);
        txn(1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0);
`else
        txn(1'b0, 2'd2, 1'b0, 32'h103, 32'h0);          // low bits forced
        txn(1'b1, 2'd1, 1'b0, 32'h3FF, 32'h0000BEEF);
`endif

        // Reset while an SB is in its read cycle: no write, no response.
        ra = gold_word(32'h104);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd0;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h105; bus.req_wdata = 32'h5A;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        chk("rd_state_re", {31'b0, bus.mem_re}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready", {31'b0, bus.req_ready}, 32'd1);
        chk("rst_mid_rsp", {31'b0, bus.rsp_valid}, 32'd0);
        chk("rst_mid_we", {31'b0, bus.mem_we}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_rsp2", {31'b0, bus.rsp_valid}, 32'd0);
        chk("rst_mid_mem", dmem[32'h104/4], ra);

        // Random back-to-back traffic.
        for (int i = 0; i < 400; i++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            sz = 2'($urandom_range(0, 3));
`ifdef LSU_ADDR_CHECK_EN
            a = 32'($urandom_range(0, MEM_BYTES + 16));
`else
            a = 32'($urandom_range(0, MEM_BYTES - 1));
`endif
            txn(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
